// File: rtl/hazard_detect_unit_pkg.sv
// Shared pipeline package for the hazard detection / forwarding slice.
// Holds the register-file geometry, the MD counter width and the MD
// sequencer state encoding.
package hazard_detect_unit_pkg;

  localparam int REGS  = 16;
  localparam int REG_W = 4;

  // Wide enough for MD_LAT-1 with MD_LAT up to 15.
  localparam int CNT_W = 4;

  // MD sequencer states (plain constants so older tools can read them).
  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

endpackage

// File: rtl/hazard_detect_unit_if.sv
// ID-stage / hazard-unit bundle.
//   master : pipeline side, drives the ID/EX fields, receives stall and MD status
//   slave  : hazard_detect_unit side
// Handshake: mdStart is a one-cycle issue strobe that the MD unit accepts
// unconditionally; mdWb is a one-cycle completion strobe, mdDest valid with it.
interface hazard_detect_unit_if;
  import hazard_detect_unit_pkg::*;

  logic             idValid;
  logic             idFlush;
  logic [REG_W-1:0] idReg1;
  logic [REG_W-1:0] idReg2;
  logic             idUse1;
  logic             idUse2;
  logic             idWrite;
  logic [REG_W-1:0] idDest;
  logic             idIsMd;
  logic             exMemRead;
  logic [REG_W-1:0] exRegDest;
  logic             stall;
  logic             bubble;
  logic             mdStart;
  logic             mdBusy;
  logic             mdWb;
  logic [REG_W-1:0] mdDest;

  modport master (
    output idValid, idFlush, idReg1, idReg2, idUse1, idUse2, idWrite, idDest,
           idIsMd, exMemRead, exRegDest,
    input  stall, bubble, mdStart, mdBusy, mdWb, mdDest
  );

  modport slave (
    input  idValid, idFlush, idReg1, idReg2, idUse1, idUse2, idWrite, idDest,
           idIsMd, exMemRead, exRegDest,
    output stall, bubble, mdStart, mdBusy, mdWb, mdDest
  );

endinterface

// File: rtl/hazard_detect_unit_md_scoreboard.sv
// md_scoreboard: one pending bit per architectural register, set when an MD
// op issues and cleared at the end of its writeback cycle.
//   set_en/set_idx : MD issue this cycle, destination register
//   clr_en/clr_idx : MD writeback this cycle, destination register
//   pending        : registered pending vector
// A set and clear of the same bit in one cycle leaves it set, because the
// newly issued op still owes a write to that register.
module md_scoreboard
  import hazard_detect_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  output logic [REGS-1:0]  pending
);

  logic [REGS-1:0] pending_q;
  logic [REGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_idx] = 1'b0;
    // Applied last so it overrides a clear of the same bit.
    if (set_en) pending_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: stalls ID for hazards forwarding cannot cover (load-use
// against EX, RAW/WAW against the fixed-latency MD unit, MD structural) and
// owns the MD issue sequencer.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : ID/EX fields in; stall, bubble, mdStart, mdBusy, mdWb, mdDest out
//   dbg_md_state  : current MD sequencer state
module hazard_detect_unit
  import hazard_detect_unit_pkg::*;
#(
  parameter int MD_LAT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_detect_unit_if.slave  bus,
  output logic [0:0]           dbg_md_state
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);

  logic [0:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             md_wb_q,   md_wb_d;
  logic [REG_W-1:0] md_dest_q, md_dest_d;

  logic [REGS-1:0]  pending;
  logic             md_busy;
  logic             id_live;
  logic             load_use, raw_md, waw_md, md_struct;
  logic             stall_c, md_start_c;

  assign md_busy = (state_q == MD_BUSY);

  // Hazard terms; all gated by a live (valid, unflushed) ID instruction.
  always_comb begin
    id_live   = bus.idValid && !bus.idFlush;
    load_use  = bus.exMemRead &&
                ((bus.idUse1 && (bus.idReg1 == bus.exRegDest)) ||
                 (bus.idUse2 && (bus.idReg2 == bus.exRegDest)));
    raw_md    = (bus.idUse1 && pending[bus.idReg1]) ||
                (bus.idUse2 && pending[bus.idReg2]);
    waw_md    = bus.idWrite && pending[bus.idDest];
    // The writeback cycle frees the unit, so an MD op may issue back-to-back.
    md_struct = bus.idIsMd && md_busy && !md_wb_q;
    stall_c   = id_live && (load_use || raw_md || waw_md || md_struct);
    md_start_c = id_live && bus.idIsMd && !stall_c;
  end

  // MD sequencer: count MD_LAT-1 down to 0; mdWb is registered so it is
  // predicted one cycle early from the next-state values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_dest_d = md_dest_q;
    if (md_start_c) begin
      state_d   = MD_BUSY;
      cnt_d     = CNT_LOAD;
      md_dest_d = bus.idDest;
    end else if (md_wb_q) begin
      state_d = MD_IDLE;
    end else if (md_busy && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    md_wb_d = (state_d == MD_BUSY) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      md_wb_q   <= 1'b0;
      md_dest_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_wb_q   <= md_wb_d;
      md_dest_q <= md_dest_d;
    end
  end

  md_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (md_start_c),
    .set_idx (bus.idDest),
    .clr_en  (md_wb_q),
    .clr_idx (md_dest_q),
    .pending (pending)
  );

  assign bus.stall    = stall_c;
  assign bus.bubble   = stall_c;
  assign bus.mdStart  = md_start_c;
  assign bus.mdBusy   = md_busy;
  assign bus.mdWb     = md_wb_q;
  assign bus.mdDest   = md_dest_q;
  assign dbg_md_state = state_q;

endmodule

// File: tb/tb_hazard_detect_unit.sv
module tb_hazard_detect_unit;
  import hazard_detect_unit_pkg::*;

  localparam int LAT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] dbg_md_state;

  hazard_detect_unit_if bus();

  hazard_detect_unit #(.MD_LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .dbg_md_state (dbg_md_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_id(input logic v, input logic [3:0] r1, input logic u1,
                        input logic [3:0] r2, input logic u2, input logic wr,
                        input logic [3:0] dst, input logic md);
    bus.idValid = v;  bus.idFlush = 1'b0;
    bus.idReg1 = r1;  bus.idUse1 = u1;
    bus.idReg2 = r2;  bus.idUse2 = u2;
    bus.idWrite = wr; bus.idDest = dst; bus.idIsMd = md;
    bus.exMemRead = 1'b0; bus.exRegDest = 4'd0;
  endtask

  task automatic idle_in();
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One cycle: compare outputs at negedge, then advance past the next edge.
  task automatic tick(input string n, input logic s, input logic st,
                      input logic b, input logic w, input logic [3:0] d);
    @(negedge clk);
    check({n, ".stall"},   bus.stall,   s);
    check({n, ".bubble"},  bus.bubble,  s);
    check({n, ".mdStart"}, bus.mdStart, st);
    check({n, ".mdBusy"},  bus.mdBusy,  b);
    check({n, ".mdWb"},    bus.mdWb,    w);
    check({n, ".mdDest"},  bus.mdDest,  d);
    @(posedge clk); #1;
  endtask

  // ---------------- combinational vector table ----------------
  typedef struct {
    logic v, fl;
    logic [3:0] r1, r2;
    logic u1, u2, wr;
    logic [3:0] dst;
    logic md, exl;
    logic [3:0] exd;
    logic e_stall, e_start;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic v, input logic fl, input logic [3:0] r1, input logic u1,
                         input logic [3:0] r2, input logic u2, input logic wr,
                         input logic [3:0] dst, input logic md, input logic exl,
                         input logic [3:0] exd, input logic es, input logic est);
    vec_t t;
    t.v = v; t.fl = fl; t.r1 = r1; t.u1 = u1; t.r2 = r2; t.u2 = u2; t.wr = wr;
    t.dst = dst; t.md = md; t.exl = exl; t.exd = exd; t.e_stall = es; t.e_start = est;
    vecs.push_back(t);
  endtask

  // ---------------- reference model ----------------
  // Each register remembers the cycle its outstanding MD write lands;
  // it reads as pending up to and including that cycle.
  int   cyc;
  int   pend_until[REGS];
  int   wb_at;
  bit   active;
  logic [3:0] m_dest;

  task automatic model_reset();
    for (int r = 0; r < REGS; r++) pend_until[r] = -1;
    active = 0; wb_at = -1; m_dest = 4'd0;
  endtask

  initial begin
    logic live, lu, raw, waw, busy, wbn, strc, e_stall, e_start;

    rst = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    @(negedge clk);
    check("reset.stall",  bus.stall,  1'b0);
    check("reset.mdBusy", bus.mdBusy, 1'b0);
    check("reset.mdWb",   bus.mdWb,   1'b0);
    check("reset.mdDest", bus.mdDest, 4'd0);
    check("reset.state",  dbg_md_state, MD_IDLE);

    // Table vectors, applied while reset holds all state clear.
    //       v  fl r1    u1 r2    u2 wr dst   md exl exd   stall start
    add_vec(1, 0, 4'd5, 1, 4'd0, 0, 0, 4'd0, 0, 1, 4'd5, 1, 0);
    add_vec(1, 0, 4'd1, 0, 4'd7, 1, 0, 4'd0, 0, 1, 4'd7, 1, 0);
    add_vec(1, 0, 4'd5, 0, 4'd0, 0, 0, 4'd0, 0, 1, 4'd5, 0, 0);
    add_vec(1, 0, 4'd4, 1, 4'd6, 1, 0, 4'd0, 0, 1, 4'd5, 0, 0);
    add_vec(1, 0, 4'd5, 1, 4'd0, 0, 0, 4'd0, 0, 0, 4'd5, 0, 0);
    add_vec(0, 0, 4'd5, 1, 4'd0, 0, 0, 4'd0, 0, 1, 4'd5, 0, 0);
    add_vec(1, 1, 4'd5, 1, 4'd0, 0, 0, 4'd0, 0, 1, 4'd5, 0, 0);
    add_vec(1, 0, 4'd1, 1, 4'd2, 1, 1, 4'd3, 1, 0, 4'd0, 0, 1);
    add_vec(1, 0, 4'd5, 1, 4'd0, 0, 1, 4'd3, 1, 1, 4'd5, 1, 0);
    add_vec(1, 1, 4'd1, 1, 4'd2, 1, 1, 4'd3, 1, 0, 4'd0, 0, 0);
    add_vec(0, 0, 4'd1, 1, 4'd2, 1, 1, 4'd3, 1, 0, 4'd0, 0, 0);
    add_vec(1, 0, 4'd0, 1, 4'd0, 0, 0, 4'd0, 0, 1, 4'd0, 1, 0);
    foreach (vecs[i]) begin
      @(posedge clk); #2;
      set_id(vecs[i].v, vecs[i].r1, vecs[i].u1, vecs[i].r2, vecs[i].u2,
             vecs[i].wr, vecs[i].dst, vecs[i].md);
      bus.idFlush = vecs[i].fl; bus.exMemRead = vecs[i].exl; bus.exRegDest = vecs[i].exd;
      #2;
      check($sformatf("vec%0d.stall", i),   bus.stall,   vecs[i].e_stall);
      check($sformatf("vec%0d.bubble", i),  bus.bubble,  vecs[i].e_stall);
      check($sformatf("vec%0d.mdStart", i), bus.mdStart, vecs[i].e_start);
    end
    do_reset();

    // A: load-use, one stall then clear
    set_id(1, 4'd5, 1, 4'd0, 0, 0, 4'd0, 0); bus.exMemRead = 1; bus.exRegDest = 4'd5;
    tick("lu0", 1, 0, 0, 0, 4'd0);
    bus.exMemRead = 0;
    tick("lu1", 0, 0, 0, 0, 4'd0);

    // B: MD issue, reader of R3 stalls through writeback
    set_id(1, 4'd1, 1, 4'd2, 1, 1, 4'd3, 1);
    tick("b_issue", 0, 1, 0, 0, 4'd0);
    set_id(1, 4'd3, 1, 4'd0, 0, 0, 4'd0, 0);
    for (int i = 1; i <= LAT; i++) tick($sformatf("b_raw%0d", i), 1, 0, 1, (i == LAT), 4'd3);
    tick("b_free", 0, 0, 0, 0, 4'd3);

    // C: structural stall then back-to-back issue in the writeback cycle
    set_id(1, 4'd0, 0, 4'd0, 0, 1, 4'd3, 1);
    tick("c_issue", 0, 1, 0, 0, 4'd3);
    idle_in();
    for (int i = 1; i <= 2; i++) tick("c_idle", 0, 0, 1, 0, 4'd3);
    set_id(1, 4'd0, 0, 4'd0, 0, 1, 4'd6, 1);
    for (int i = 3; i < LAT; i++) tick($sformatf("c_struct%0d", i), 1, 0, 1, 0, 4'd3);
    tick("c_b2b", 0, 1, 1, 1, 4'd3);
    idle_in();
    for (int i = 1; i < LAT; i++) tick("c_second", 0, 0, 1, 0, 4'd6);
    tick("c_wb2", 0, 0, 1, 1, 4'd6);
    tick("c_done", 0, 0, 0, 0, 4'd6);

    // D: same destination re-issued in the writeback cycle keeps its pending bit
    set_id(1, 4'd0, 0, 4'd0, 0, 1, 4'd4, 1);
    tick("d_issue", 0, 1, 0, 0, 4'd6);
    idle_in();
    for (int i = 1; i < LAT; i++) tick("d_wait", 0, 0, 1, 0, 4'd4);
    set_id(1, 4'd0, 0, 4'd0, 0, 0, 4'd4, 1);
    tick("d_reissue", 0, 1, 1, 1, 4'd4);
    set_id(1, 4'd4, 1, 4'd0, 0, 0, 4'd0, 0);
    tick("d_setwins", 1, 0, 1, 0, 4'd4);
    do_reset();

    // E: reset mid-operation abandons the MD op
    set_id(1, 4'd0, 0, 4'd0, 0, 1, 4'd3, 1);
    tick("e_issue", 0, 1, 0, 0, 4'd0);
    idle_in();
    for (int i = 1; i <= 3; i++) tick("e_busy", 0, 0, 1, 0, 4'd3);
    rst = 1;
    tick("e_rst", 0, 0, 1, 0, 4'd3);
    rst = 0;
    set_id(1, 4'd3, 1, 4'd0, 0, 0, 4'd0, 0);
    tick("e_reader", 0, 0, 0, 0, 4'd0);
    idle_in();
    for (int i = 6; i <= LAT; i++) tick($sformatf("e_nowb%0d", i), 0, 0, 0, 0, 4'd0);

    // F: flush and unused sources suppress the stall
    set_id(1, 4'd0, 0, 4'd0, 0, 1, 4'd3, 1);
    tick("f_issue", 0, 1, 0, 0, 4'd0);
    set_id(1, 4'd3, 1, 4'd0, 0, 0, 4'd0, 0); bus.idFlush = 1;
    tick("f_flush_raw", 0, 0, 1, 0, 4'd3);
    set_id(1, 4'd0, 0, 4'd0, 0, 1, 4'd9, 1); bus.idFlush = 1;
    tick("f_flush_md", 0, 0, 1, 0, 4'd3);
    set_id(1, 4'd3, 0, 4'd3, 0, 0, 4'd0, 0);
    tick("f_unused", 0, 0, 1, 0, 4'd3);
    set_id(1, 4'd0, 0, 4'd0, 0, 1, 4'd3, 0);
    tick("f_waw", 1, 0, 1, 0, 4'd3);
    do_reset();

    // Random phase against the reference model
    model_reset();
    cyc = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      set_id($urandom_range(0, 9) != 0, 4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 5)), $urandom_range(0, 3) == 0);
      bus.idFlush   = ($urandom_range(0, 9) == 0);
      bus.exMemRead = ($urandom_range(0, 3) == 0);
      bus.exRegDest = 4'($urandom_range(0, 5));

      @(negedge clk);
      live = bus.idValid && !bus.idFlush;
      lu   = bus.exMemRead && ((bus.idUse1 && bus.idReg1 == bus.exRegDest) ||
                               (bus.idUse2 && bus.idReg2 == bus.exRegDest));
      raw  = (bus.idUse1 && cyc <= pend_until[bus.idReg1]) ||
             (bus.idUse2 && cyc <= pend_until[bus.idReg2]);
      waw  = bus.idWrite && cyc <= pend_until[bus.idDest];
      busy = active && cyc <= wb_at;
      wbn  = active && cyc == wb_at;
      strc = bus.idIsMd && busy && !wbn;
      e_stall = live && (lu || raw || waw || strc);
      e_start = live && bus.idIsMd && !e_stall;
      check("rnd.stall",   bus.stall,   e_stall);
      check("rnd.bubble",  bus.bubble,  e_stall);
      check("rnd.mdStart", bus.mdStart, e_start);
      check("rnd.mdBusy",  bus.mdBusy,  busy);
      check("rnd.mdWb",    bus.mdWb,    wbn);
      check("rnd.mdDest",  bus.mdDest,  m_dest);

      @(posedge clk);
      if (rst) model_reset();
      else if (e_start) begin
        active = 1;
        wb_at  = cyc + LAT;
        pend_until[bus.idDest] = cyc + LAT;
        m_dest = bus.idDest;
      end
      cyc++;
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
